seq_divider: RTL and testbench

- Iterative restoring divider: unsigned dividend / unsigned divisor, producing quotient and remainder. Arithmetic inverse of the lookup-table 4x4 multiplier.
- Results can be cross-checked against products from the multiplier (product / rhs == lhs, remainder 0).
- Computes one quotient bit per cycle.
- Valid/ready handshake on both the request side and the response side, so it sits behind any producer and in front of any consumer.

---
 rtl/seq_divider.sv | 107 ++++++++++
 tb/tb_seq_divider.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, valid/ready on both sides.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and a flag.
`timescale 1ns/1ps
module seq_divider #(
    parameter int DIVIDEND_WIDTH = 8,
    parameter int DIVISOR_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_in_valid,
    output logic                      io_in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] io_in_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  io_in_divisor,
    output logic                      io_out_valid,
    input  logic                      io_out_ready,
    output logic [DIVIDEND_WIDTH-1:0] io_out_quotient,
    output logic [DIVISOR_WIDTH-1:0]  io_out_remainder,
    output logic                      io_out_div_by_zero
);

    localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      state;
    logic [DIVIDEND_WIDTH-1:0]   q;
    logic [DIVISOR_WIDTH-1:0]    d;
    logic [DIVISOR_WIDTH-1:0]    r;
    logic [CW-1:0]               cnt;
    logic                        dbz;

    logic [DIVISOR_WIDTH:0]      r_sh;
    logic [DIVISOR_WIDTH:0]      r_diff;
    logic [DIVISOR_WIDTH-1:0]    r_nxt;
    logic [DIVIDEND_WIDTH-1:0]   q_nxt;

    // Partial remainder always stays below D, so its top bit is implicitly zero and
    // the MSB of the extended difference is the borrow (set means R' < D).
    always_comb begin
        r_sh   = {r, q[DIVIDEND_WIDTH-1]};
        r_diff = r_sh - {1'b0, d};
        r_nxt  = r_sh[DIVISOR_WIDTH-1:0];
        q_nxt  = {q[DIVIDEND_WIDTH-2:0], 1'b0};
        if (!r_diff[DIVISOR_WIDTH]) begin
            r_nxt = r_diff[DIVISOR_WIDTH-1:0];
            q_nxt = {q[DIVIDEND_WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            q                  <= '0;
            d                  <= '0;
            r                  <= '0;
            cnt                <= '0;
            dbz                <= 1'b0;
            io_in_ready        <= 1'b1;
            io_out_valid       <= 1'b0;
            io_out_quotient    <= '0;
            io_out_remainder   <= '0;
            io_out_div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        q           <= io_in_dividend;
                        d           <= io_in_divisor;
                        r           <= '0;
                        cnt         <= CW'(DIVIDEND_WIDTH - 1);
                        io_in_ready <= 1'b0;
                        if (io_in_divisor == '0) begin
                            q     <= '1;
                            r     <= io_in_dividend[DIVISOR_WIDTH-1:0];
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else begin
                            dbz   <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!io_out_valid) begin
                        io_out_valid       <= 1'b1;
                        io_out_quotient    <= q;
                        io_out_remainder   <= r;
                        io_out_div_by_zero <= dbz;
                    end else if (io_out_ready) begin
                        io_out_valid <= 1'b0;
                        io_in_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: table of hand-computed cases, backpressure,
// mid-operation reset, product sweep and random invariant checks.
`timescale 1ns/1ps
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_in_valid;
    logic       io_in_ready;
    logic [7:0] io_in_dividend;
    logic [3:0] io_in_divisor;
    logic       io_out_valid;
    logic       io_out_ready;
    logic [7:0] io_out_quotient;
    logic [3:0] io_out_remainder;
    logic       io_out_div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.DIVIDEND_WIDTH(8), .DIVISOR_WIDTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .io_in_valid        (io_in_valid),
        .io_in_ready        (io_in_ready),
        .io_in_dividend     (io_in_dividend),
        .io_in_divisor      (io_in_divisor),
        .io_out_valid       (io_out_valid),
        .io_out_ready       (io_out_ready),
        .io_out_quotient    (io_out_quotient),
        .io_out_remainder   (io_out_remainder),
        .io_out_div_by_zero (io_out_div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dsr;
        int         stall;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issues one request, checks latency, optional stall, result and handshake back to IDLE.
    task automatic run_div(input logic [7:0] dvd, input logic [3:0] dsr, input int stall,
                           input logic [7:0] eq, input logic [3:0] er, input logic ez,
                           input int elat, output logic [7:0] q, output logic [3:0] r);
        int n;
        int lat;
        n = 0;
        while (!io_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_req", {31'd0, io_in_ready}, 32'd1);
        io_in_dividend = dvd;
        io_in_divisor  = dsr;
        io_in_valid    = 1'b1;
        io_out_ready   = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_accept", {31'd0, io_in_ready}, 32'd0);
        lat = 0;
        while (!io_out_valid && lat < 40) begin
            // Junk on the request side while busy must be ignored.
            io_in_dividend = 8'($urandom);
            io_in_divisor  = 4'($urandom);
            io_in_valid    = 1'($urandom_range(0, 1));
            io_out_ready   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b0;
        chk("latency", lat, elat);
        chk("quotient", {24'd0, io_out_quotient}, {24'd0, eq});
        chk("remainder", {28'd0, io_out_remainder}, {28'd0, er});
        chk("div_by_zero", {31'd0, io_out_div_by_zero}, {31'd0, ez});
        q = io_out_quotient;
        r = io_out_remainder;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, io_out_valid}, 32'd1);
            chk("stall_in_ready", {31'd0, io_in_ready}, 32'd0);
            chk("stall_quotient", {24'd0, io_out_quotient}, {24'd0, eq});
            chk("stall_remainder", {28'd0, io_out_remainder}, {28'd0, er});
        end
        io_out_ready = 1'b1;
        @(posedge clk); #1;
        io_out_ready = 1'b0;
        chk("valid_drop", {31'd0, io_out_valid}, 32'd0);
        chk("in_ready_idle", {31'd0, io_in_ready}, 32'd1);
    endtask

    vec_t       vecs[$];
    logic [7:0] gq;
    logic [3:0] gr;
    logic [7:0] rd;
    logic [3:0] rs;
    int         seen;

    initial begin
        reset          = 1'b1;
        io_in_valid    = 1'b0;
        io_in_dividend = '0;
        io_in_divisor  = '0;
        io_out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, io_in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rst_quotient", {24'd0, io_out_quotient}, 32'd0);
        chk("rst_remainder", {28'd0, io_out_remainder}, 32'd0);
        chk("rst_dbz", {31'd0, io_out_div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        vecs.push_back('{8'd225, 4'd15, 0, 8'd15,  4'd0, 1'b0, 9});
        vecs.push_back('{8'd255, 4'd4,  0, 8'd63,  4'd3, 1'b0, 9});
        vecs.push_back('{8'd7,   4'd9,  0, 8'd0,   4'd7, 1'b0, 9});
        vecs.push_back('{8'd15,  4'd1,  0, 8'd15,  4'd0, 1'b0, 9});
        vecs.push_back('{8'd200, 4'd0,  0, 8'hFF,  4'd8, 1'b1, 1});
        vecs.push_back('{8'd0,   4'd5,  0, 8'd0,   4'd0, 1'b0, 9});
        vecs.push_back('{8'd255, 4'd15, 0, 8'd17,  4'd0, 1'b0, 9});
        vecs.push_back('{8'd255, 4'd1,  0, 8'd255, 4'd0, 1'b0, 9});
        vecs.push_back('{8'd254, 4'd13, 2, 8'd19,  4'd7, 1'b0, 9});
        vecs.push_back('{8'd0,   4'd0,  1, 8'hFF,  4'd0, 1'b1, 1});
        vecs.push_back('{8'd100, 4'd7, 20, 8'd14,  4'd2, 1'b0, 9});
        vecs.push_back('{8'd6,   4'd3,  0, 8'd2,   4'd0, 1'b0, 9});
        foreach (vecs[i])
            run_div(vecs[i].dvd, vecs[i].dsr, vecs[i].stall, vecs[i].q, vecs[i].r,
                    vecs[i].z, vecs[i].lat, gq, gr);

        // Reset four cycles into 180/11: nothing may come out afterwards.
        io_in_dividend = 8'd180;
        io_in_divisor  = 4'd11;
        io_in_valid    = 1'b1;
        @(posedge clk); #1;
        io_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, io_in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        io_out_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (io_out_valid) seen++;
        end
        io_out_ready = 1'b0;
        chk("midrst_no_result", seen, 0);
        run_div(8'd180, 4'd11, 0, 8'd16, 4'd4, 1'b0, 9, gq, gr);

        for (int lhs = 1; lhs <= 15; lhs++)
            for (int rhs = 1; rhs <= 15; rhs++)
                run_div(8'(lhs * rhs), 4'(rhs), $urandom_range(0, 3), 8'(lhs), 4'd0, 1'b0, 9, gq, gr);

        for (int k = 0; k < 60; k++) begin
            rd = 8'($urandom);
            rs = 4'($urandom_range(1, 15));
            run_div(rd, rs, $urandom_range(0, 2), rd / {4'd0, rs}, 4'(rd % {4'd0, rs}), 1'b0, 9, gq, gr);
            chk("invariant_qd_plus_r", 32'(gq) * 32'(rs) + 32'(gr), 32'(rd));
            chk("remainder_lt_divisor", {31'd0, (gr < rs)}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
